// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory req/ack handshake and MEM/WB pipeline register.
// Optional access timeout compiled in with MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        MEM_Link,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_WriteData,
  input  logic [31:0] MEM_PCPlus4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  input  logic        err_clr,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] WB_Result,
  output logic        err_misalign,
  output logic        err_timeout
);

  if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
    $error("mem_wb_stage: TIMEOUT must be in 2..256");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        access, misaligned;
  logic        req, stall, bubble, mis_set, to_set, timeout_hit;
  logic [31:0] result;

  assign access     = MemtoRegM | MemWriteM;
  assign misaligned = access & (MEM_ALUOut[1:0] != 2'b00);
  assign result     = MEM_Link ? MEM_PCPlus4 : (MemtoRegM ? dmem_rdata : MEM_ALUOut);

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE)
      cnt_d = (state_d == S_WAIT) ? CW'(1) : '0;
    else if (state_d == S_IDLE)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    mis_set = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (misaligned) begin
          bubble  = 1'b1;
          mis_set = 1'b1;
        end else if (access) begin
          req = 1'b1;
          if (!dmem_ack) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An ack in the final counted cycle still completes the access.
        if (dmem_ack) begin
          req     = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          bubble  = 1'b1;
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          req    = 1'b1;
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dmem_req   = req & ~rst;
  assign StallM     = stall & ~rst;
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = MEM_ALUOut;
  assign dmem_wdata = MEM_WriteData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      RegWriteW    <= 1'b0;
      WriteRegW    <= '0;
      WB_Result    <= '0;
      err_misalign <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_misalign <= mis_set | (err_misalign & ~err_clr);
      if (bubble) begin
        RegWriteW <= 1'b0;
        WriteRegW <= '0;
        WB_Result <= '0;
      end else begin
        RegWriteW <= RegWriteM;
        WriteRegW <= WriteRegM;
        WB_Result <= result;
      end
    end
  end

`ifdef MEM_WB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_timeout <= 1'b0;
    else     err_timeout <= to_set | (err_timeout & ~err_clr);
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage built with TIMEOUT=4.
module tb_mem_wb_stage;
  logic        clk = 0, rst = 1;
  logic        RegWriteM, MemtoRegM, MemWriteM, MEM_Link, dmem_ack, err_clr;
  logic [4:0]  WriteRegM;
  logic [31:0] MEM_ALUOut, MEM_WriteData, MEM_PCPlus4, dmem_rdata;
  logic        dmem_req, dmem_we, StallM, RegWriteW, err_misalign, err_timeout;
  logic [4:0]  WriteRegW;
  logic [31:0] dmem_addr, dmem_wdata, WB_Result;
  int vecs = 0, miss = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .MEM_Link(MEM_Link), .WriteRegM(WriteRegM),
    .MEM_ALUOut(MEM_ALUOut), .MEM_WriteData(MEM_WriteData), .MEM_PCPlus4(MEM_PCPlus4),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .StallM(StallM), .err_clr(err_clr),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .WB_Result(WB_Result),
    .err_misalign(err_misalign), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; MEM_Link = 0; WriteRegM = 0;
    MEM_ALUOut = 0; MEM_WriteData = 0; MEM_PCPlus4 = 0; dmem_rdata = 0;
    dmem_ack = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1;
    MemtoRegM = 1; RegWriteM = 1; MEM_ALUOut = 32'h100; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL reset_req_stall got %b exp 00", {dmem_req, StallM}); end
    tick();
    vecs++; if ({RegWriteW, WriteRegW, WB_Result, err_misalign, err_timeout} !== 40'd0) begin
      miss++; $display("FAIL reset_regs got %b %h %h %b %b exp zeros", RegWriteW, WriteRegW, WB_Result, err_misalign, err_timeout); end
    idle_in(); rst = 0; tick();
  endtask

  task automatic test_alu();
    idle_in(); RegWriteM = 1; WriteRegM = 5; MEM_ALUOut = 32'h1234; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL alu_req_stall got %b exp 00", {dmem_req, StallM}); end
    tick();
    vecs++; if ({RegWriteW, WriteRegW, WB_Result} !== {1'b1, 5'd5, 32'h1234}) begin
      miss++; $display("FAIL alu_wb got %b %0d %h exp 1 5 00001234", RegWriteW, WriteRegW, WB_Result); end
  endtask

  task automatic test_load_wait();
    idle_in(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 7; MEM_ALUOut = 32'h100;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if ({dmem_req, dmem_we, StallM, dmem_addr} !== {3'b101, 32'h100}) begin
        miss++; $display("FAIL load_wait_c%0d got req=%b we=%b stall=%b addr=%h exp 1 0 1 00000100", c, dmem_req, dmem_we, StallM, dmem_addr); end
      tick();
      vecs++; if ({RegWriteW, WriteRegW, WB_Result} !== 38'd0) begin
        miss++; $display("FAIL load_bubble_c%0d got %b %0d %h exp 0 0 0", c, RegWriteW, WriteRegW, WB_Result); end
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    vecs++; if ({dmem_req, dmem_we, StallM} !== 3'b100) begin
      miss++; $display("FAIL load_ack got req=%b we=%b stall=%b exp 1 0 0", dmem_req, dmem_we, StallM); end
    tick();
    vecs++; if ({RegWriteW, WriteRegW, WB_Result} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
      miss++; $display("FAIL load_result got %b %0d %h exp 1 7 deadbeef", RegWriteW, WriteRegW, WB_Result); end
  endtask

  task automatic test_store_zero_wait();
    idle_in(); RegWriteM = 0; MemWriteM = 1; WriteRegM = 3; MEM_ALUOut = 32'h20;
    MEM_WriteData = 32'hA5A5A5A5; dmem_ack = 1; #1;
    vecs++; if ({dmem_req, dmem_we, StallM, dmem_addr, dmem_wdata} !== {3'b110, 32'h20, 32'hA5A5A5A5}) begin
      miss++; $display("FAIL store_comb got req=%b we=%b stall=%b addr=%h wd=%h exp 1 1 0 00000020 a5a5a5a5", dmem_req, dmem_we, StallM, dmem_addr, dmem_wdata); end
    tick();
    vecs++; if ({RegWriteW, WriteRegW} !== {1'b0, 5'd3}) begin
      miss++; $display("FAIL store_wb got %b %0d exp 0 3", RegWriteW, WriteRegW); end
  endtask

  task automatic test_link_and_ack_idle();
    idle_in(); MEM_Link = 1; RegWriteM = 1; WriteRegM = 31; MEM_PCPlus4 = 32'h400; MEM_ALUOut = 32'h999;
    dmem_ack = 1; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL link_req got %b exp 00", {dmem_req, StallM}); end
    tick();
    vecs++; if ({RegWriteW, WriteRegW, WB_Result} !== {1'b1, 5'd31, 32'h400}) begin
      miss++; $display("FAIL link_wb got %b %0d %h exp 1 31 00000400", RegWriteW, WriteRegW, WB_Result); end
  endtask

  task automatic test_misalign();
    idle_in(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 9; MEM_ALUOut = 32'h102; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL mis_req got %b exp 00", {dmem_req, StallM}); end
    tick();
    vecs++; if ({RegWriteW, err_misalign} !== 2'b01) begin
      miss++; $display("FAIL mis_bubble got rw=%b err=%b exp 0 1", RegWriteW, err_misalign); end
    idle_in(); tick(); tick();
    vecs++; if (err_misalign !== 1'b1) begin miss++; $display("FAIL mis_sticky got %b exp 1", err_misalign); end
    MemtoRegM = 1; MEM_ALUOut = 32'h3; err_clr = 1; tick();
    vecs++; if (err_misalign !== 1'b1) begin miss++; $display("FAIL mis_set_wins got %b exp 1", err_misalign); end
    idle_in(); err_clr = 1; tick();
    vecs++; if (err_misalign !== 1'b0) begin miss++; $display("FAIL mis_clear got %b exp 0", err_misalign); end
    err_clr = 0;
  endtask

  task automatic test_timeout();
`ifdef MEM_WB_TIMEOUT_EN
    idle_in(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 4; MEM_ALUOut = 32'h40;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if ({dmem_req, StallM} !== 2'b11) begin miss++; $display("FAIL to_wait_c%0d got %b exp 11", c, {dmem_req, StallM}); end
      tick();
    end
    #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL to_drop got %b exp 00", {dmem_req, StallM}); end
    tick();
    vecs++; if ({err_timeout, RegWriteW} !== 2'b10) begin miss++; $display("FAIL to_err got err=%b rw=%b exp 1 0", err_timeout, RegWriteW); end
    idle_in(); err_clr = 1; tick(); err_clr = 0;
    vecs++; if (err_timeout !== 1'b0) begin miss++; $display("FAIL to_clear got %b exp 0", err_timeout); end
    RegWriteM = 1; MemtoRegM = 1; WriteRegM = 4; MEM_ALUOut = 32'h40;
    tick(); tick(); tick();
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b10) begin miss++; $display("FAIL to_lastack got %b exp 10", {dmem_req, StallM}); end
    tick();
    vecs++; if ({err_timeout, RegWriteW, WB_Result} !== {2'b01, 32'h0BADF00D}) begin
      miss++; $display("FAIL to_lastack_wb got err=%b rw=%b res=%h exp 0 1 0badf00d", err_timeout, RegWriteW, WB_Result); end
`else
    idle_in(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 4; MEM_ALUOut = 32'h40;
    for (int c = 0; c < 12; c++) tick();
    vecs++; if ({dmem_req, StallM, err_timeout} !== 3'b110) begin
      miss++; $display("FAIL nowait_hold got %b exp 110", {dmem_req, StallM, err_timeout}); end
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D; tick();
    vecs++; if ({RegWriteW, WB_Result} !== {1'b1, 32'h0BADF00D}) begin
      miss++; $display("FAIL nowait_done got %b %h exp 1 0badf00d", RegWriteW, WB_Result); end
`endif
    idle_in();
  endtask

  task automatic test_reset_wait();
    idle_in(); MemtoRegM = 1; MEM_ALUOut = 32'h1; tick();
    RegWriteM = 1; MEM_ALUOut = 32'h80; tick(); tick();
    rst = 1; #1;
    vecs++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL rstw_comb got %b exp 00", {dmem_req, StallM}); end
    vecs++; if ({RegWriteW, WriteRegW, WB_Result, err_misalign, err_timeout} !== 40'd0) begin
      miss++; $display("FAIL rstw_regs got %b %h %h %b %b exp zeros", RegWriteW, WriteRegW, WB_Result, err_misalign, err_timeout); end
    tick(); rst = 0; MEM_ALUOut = 32'h82; #1;
    // Misaligned access issues no request only if the FSM is back in IDLE.
    vecs++; if (dmem_req !== 1'b0) begin miss++; $display("FAIL rstw_idle got req=%b exp 0", dmem_req); end
    tick();
    vecs++; if (err_misalign !== 1'b1) begin miss++; $display("FAIL rstw_mis got %b exp 1", err_misalign); end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_alu();
    test_load_wait();
    test_store_zero_wait();
    test_link_and_ack_idle();
    test_misalign();
    test_timeout();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
